uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with J1-bus register reads; buffer is a FIFO_DEPTH circular FIFO when UART_RX_FIFO_EN is defined, else one holding register.
// Reads return data one clock after cs&rd; a push into a full buffer is dropped and flagged as overrun (no backpressure on the line).
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   input  logic        uart_rx,
   input  logic        cs,
   input  logic        rd,
   input  logic [1:0]  addr,
   output logic [15:0] d_out,
   output logic        rx_led
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           r_state;
   logic [1:0]       r_sync;
   logic             r_rx_prev;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;
   logic [OCC_W-1:0] r_count;
   logic             r_frame_err;
   logic             r_overrun;

   logic       w_rx;
   logic       w_expire;
   logic       w_push;
   logic       w_ferr;
   logic       w_rd_data;
   logic       w_rd_stat;
   logic       w_not_empty;
   logic       w_full;
   logic       w_pop;
   logic       w_wr;
   logic       w_ovf;
   logic [7:0] w_head;

   assign w_rx     = r_sync[1];
   assign w_expire = (r_cnt == '0);
   assign w_push   = (r_state == STOP) && w_expire && w_rx;
   assign w_ferr   = (r_state == STOP) && w_expire && !w_rx;

   // Falling-edge detect needs the previous sample high, so a line still low after a bad stop bit cannot re-trigger.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         r_state   <= IDLE;
         r_sync    <= 2'b11;
         r_rx_prev <= 1'b1;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         rx_led    <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], uart_rx};
         r_rx_prev <= w_rx;
         rx_led    <= (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (r_rx_prev && !w_rx) begin
                  r_state <= START;
                  r_cnt   <= CNT_W'(CLKS_PER_BIT / 2 - 1);
               end
            end
            START: begin
               if (w_expire) begin
                  if (!w_rx) begin
                     r_state <= DATA;
                     r_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
                     r_bit   <= '0;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DATA: begin
               if (w_expire) begin
                  r_shift[r_bit] <= w_rx;
                  r_cnt          <= CNT_W'(CLKS_PER_BIT - 1);
                  if (r_bit == 3'd7) begin
                     r_state <= STOP;
                  end
                  r_bit <= r_bit + 3'd1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            STOP: begin
               if (w_expire) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_rd_data   = cs && rd && (addr == 2'd0);
   assign w_rd_stat   = cs && rd && (addr == 2'd1);
   assign w_not_empty = (r_count != '0);
   assign w_pop       = w_rd_data && w_not_empty;
   // A simultaneous pop frees a slot, so a push into a full buffer then still lands.
   assign w_wr        = w_push && (!w_full || w_pop);
   assign w_ovf       = w_push && w_full && !w_pop;

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;

   assign w_full = (r_count == OCC_W'(FIFO_DEPTH));
   assign w_head = r_mem[r_rptr];

   always_ff @(posedge sys_clk_i) begin
      if (w_wr) begin
         r_mem[r_wptr] <= r_shift;
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
      end
   end
`else
   logic [7:0] r_hold;

   assign w_full = (r_count == OCC_W'(1));
   assign w_head = r_hold;

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         r_hold <= '0;
      end else if (w_wr) begin
         r_hold <= r_shift;
      end
   end
`endif

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         r_count     <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         d_out       <= 16'h0000;
      end else begin
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + OCC_W'(1);
            2'b01:   r_count <= r_count - OCC_W'(1);
            default: r_count <= r_count;
         endcase
         // A new error in the same cycle as the clearing read wins.
         r_frame_err <= w_ferr | (r_frame_err & ~w_rd_stat);
         r_overrun   <= w_ovf  | (r_overrun   & ~w_rd_stat);
         if (cs && rd) begin
            case (addr)
               2'd0:    d_out <= w_not_empty ? {8'h00, w_head} : 16'h0000;
               2'd1:    d_out <= {13'b0, r_frame_err, r_overrun, w_not_empty};
               default: d_out <= 16'h0000;
            endcase
         end
      end
   end

endmodule
